// File: rtl/digital_signal_generator.sv
// Multi-channel PWM/pulse generator with shadow-buffered period/high settings applied at period boundaries.
// Define SIGGEN_READBACK_EN to enable configuration readback over tx_data/tx_en/tx_done.
module digital_signal_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd_opcode,
  input  logic [15:0]       cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic [NUM_CH-1:0] sig_out,
  output logic [NUM_CH-1:0] period_done,
  output logic [31:0]       tx_data,
  output logic              tx_en,
  input  logic              tx_done
);

  localparam logic [7:0] OP_MASK = 8'h20;
  localparam logic [7:0] OP_PER  = 8'h21;
  localparam logic [7:0] OP_HI   = 8'h22;
  localparam logic [7:0] OP_READ = 8'h23;

  typedef enum logic {DISABLED, RUNNING} ch_state_t;

  ch_state_t         state      [NUM_CH];
  ch_state_t         state_next [NUM_CH];
  logic [NUM_CH-1:0] en_mask;
  logic [NUM_CH-1:0] en_next;
  logic [NUM_CH-1:0] addr_hit;
  logic              addr_ok;
  logic [CNT_W-1:0]  per_sh  [NUM_CH];
  logic [CNT_W-1:0]  hi_sh   [NUM_CH];
  logic [CNT_W-1:0]  per_act [NUM_CH];
  logic [CNT_W-1:0]  hi_act  [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];

  // Enable changes act on the same edge the mask command is sampled, so the first level follows one edge later.
  always_comb begin
    en_next    = en_mask;
    addr_hit   = '0;
    state_next = '{default: DISABLED};
    if (cmd_valid && cmd_opcode == OP_MASK) en_next = cmd_data[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      addr_hit[i]   = (cmd_addr == 16'(i));
      state_next[i] = en_next[i] ? RUNNING : DISABLED;
    end
    addr_ok = |addr_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_mask <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per_sh[i] <= '0;
        hi_sh[i]  <= '0;
      end
    end else begin
      en_mask <= en_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cmd_valid && addr_hit[i] && cmd_opcode == OP_PER) per_sh[i] <= cmd_data[CNT_W-1:0];
        if (cmd_valid && addr_hit[i] && cmd_opcode == OP_HI)  hi_sh[i]  <= cmd_data[CNT_W-1:0];
      end
    end
  end

  // Active settings only ever load from the shadows at enable, at a period boundary, or while the period is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out     <= '0;
      period_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]   <= DISABLED;
        per_act[i] <= '0;
        hi_act[i]  <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]       <= state_next[i];
        sig_out[i]     <= 1'b0;
        period_done[i] <= 1'b0;
        if (state[i] == DISABLED) begin
          if (state_next[i] == RUNNING) begin
            cnt[i]     <= '0;
            per_act[i] <= per_sh[i];
            hi_act[i]  <= hi_sh[i];
          end
        end else begin
          if (per_act[i] != '0) sig_out[i] <= (cnt[i] < hi_act[i]);
          if (state_next[i] == DISABLED) begin
            cnt[i] <= '0;
          end else if (per_act[i] == '0) begin
            cnt[i]     <= '0;
            per_act[i] <= per_sh[i];
            hi_act[i]  <= hi_sh[i];
          end else if (cnt[i] == per_act[i] - CNT_W'(1)) begin
            cnt[i]         <= '0;
            per_act[i]     <= per_sh[i];
            hi_act[i]      <= hi_sh[i];
            period_done[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef SIGGEN_READBACK_EN
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_hit[i]) begin
        case (cmd_data[1:0])
          2'd0:    rd_word[CNT_W-1:0]  = per_sh[i];
          2'd1:    rd_word[CNT_W-1:0]  = hi_sh[i];
          2'd2:    rd_word[CNT_W-1:0]  = per_act[i];
          default: rd_word[NUM_CH-1:0] = en_mask;
        endcase
      end
    end
  end

  // A new readback request wins over a same-cycle tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= '0;
      tx_en   <= 1'b0;
    end else if (cmd_valid && cmd_opcode == OP_READ && addr_ok) begin
      tx_data <= rd_word;
      tx_en   <= 1'b1;
    end else if (tx_done) begin
      tx_en <= 1'b0;
    end
  end
`else
  logic unused_rb;
  assign tx_data   = '0;
  assign tx_en     = 1'b0;
  assign unused_rb = tx_done ^ addr_ok;
`endif

endmodule

// File: tb/tb_digital_signal_generator.sv
// Self-checking bench for digital_signal_generator: directed test-plan steps plus randomized commands
// compared every cycle against a period/age reference model.
module tb_digital_signal_generator;

  localparam int NCH = 4;
`ifdef SIGGEN_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [7:0]     cmd_opcode;
  logic [15:0]    cmd_addr;
  logic [31:0]    cmd_data;
  logic           cmd_valid;
  logic [NCH-1:0] sig_out;
  logic [NCH-1:0] period_done;
  logic [31:0]    tx_data;
  logic           tx_en;
  logic           tx_done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each channel is a list of settings plus how many cycles of the current period have elapsed.
  logic [NCH-1:0] m_mask;
  logic [NCH-1:0] e_sig;
  logic [NCH-1:0] e_pd;
  int unsigned    m_psh  [NCH];
  int unsigned    m_hsh  [NCH];
  int unsigned    m_pact [NCH];
  int unsigned    m_hact [NCH];
  int unsigned    m_age  [NCH];
  logic [31:0]    e_txd;
  logic           e_txen;
  int             hi_seen [NCH];
  int             pd_seen [NCH];

  digital_signal_generator #(.NUM_CH(NCH), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_opcode  (cmd_opcode),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .sig_out     (sig_out),
    .period_done (period_done),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_mask = '0;
    e_sig  = '0;
    e_pd   = '0;
    e_txd  = '0;
    e_txen = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_psh[ch]  = 0;
      m_hsh[ch]  = 0;
      m_pact[ch] = 0;
      m_hact[ch] = 0;
      m_age[ch]  = 0;
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] new_mask;
    int unsigned    a;
    a        = cmd_addr;
    new_mask = m_mask;
    if (cmd_valid && cmd_opcode == 8'h20) new_mask = cmd_data[NCH-1:0];
    if (RB_EN) begin
      if (cmd_valid && cmd_opcode == 8'h23 && a < NCH) begin
        case (cmd_data[1:0])
          2'd0:    e_txd = m_psh[a];
          2'd1:    e_txd = m_hsh[a];
          2'd2:    e_txd = m_pact[a];
          default: e_txd = 32'(m_mask);
        endcase
        e_txen = 1'b1;
      end else if (e_txen && tx_done) begin
        e_txen = 1'b0;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      e_pd[ch]  = 1'b0;
      e_sig[ch] = 1'b0;
      if (!m_mask[ch]) begin
        if (new_mask[ch]) begin
          m_age[ch]  = 0;
          m_pact[ch] = m_psh[ch];
          m_hact[ch] = m_hsh[ch];
        end
      end else begin
        e_sig[ch] = (m_pact[ch] != 0) && (m_age[ch] < m_hact[ch]);
        if (!new_mask[ch]) begin
          m_age[ch] = 0;
        end else if (m_pact[ch] == 0) begin
          m_pact[ch] = m_psh[ch];
          m_hact[ch] = m_hsh[ch];
        end else if (m_age[ch] + 1 == m_pact[ch]) begin
          m_age[ch]  = 0;
          m_pact[ch] = m_psh[ch];
          m_hact[ch] = m_hsh[ch];
          e_pd[ch]   = 1'b1;
        end else begin
          m_age[ch] = m_age[ch] + 1;
        end
      end
    end
    if (cmd_valid && cmd_opcode == 8'h21 && a < NCH) m_psh[a] = cmd_data;
    if (cmd_valid && cmd_opcode == 8'h22 && a < NCH) m_hsh[a] = cmd_data;
    m_mask = new_mask;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    checkOutput("sig_out", 32'(sig_out), 32'(e_sig));
    checkOutput("period_done", 32'(period_done), 32'(e_pd));
    checkOutput("tx_en", 32'(tx_en), 32'(e_txen));
    checkOutput("tx_data", tx_data, e_txd);
    for (int ch = 0; ch < NCH; ch++) begin
      hi_seen[ch] += int'(sig_out[ch]);
      pd_seen[ch] += int'(period_done[ch]);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] data);
    cmd_opcode = op;
    cmd_addr   = addr;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    cycle();
    cmd_valid  = 1'b0;
    cmd_opcode = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_seen();
    for (int ch = 0; ch < NCH; ch++) begin
      hi_seen[ch] = 0;
      pd_seen[ch] = 0;
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    cmd_opcode = '0;
    cmd_addr   = '0;
    cmd_data   = '0;
    cmd_valid  = 1'b0;
    tx_done    = 1'b0;
    model_reset();
    clear_seen();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset sig_out", 32'(sig_out), 32'd0);
    checkOutput("reset period_done", 32'(period_done), 32'd0);
    checkOutput("reset tx_en", 32'(tx_en), 32'd0);
    checkOutput("reset tx_data", tx_data, 32'd0);
    rst_n = 1'b1;

    $display("[TB] basic waveform ch0 per=10 hi=3");
    applyStimulus(8'h21, 16'd0, 32'd10);
    applyStimulus(8'h22, 16'd0, 32'd3);
    applyStimulus(8'h20, 16'd0, 32'h1);
    clear_seen();
    idle(1);
    checkOutput("ch0 first high", 32'(hi_seen[0]), 32'd1);
    idle(9);
    checkOutput("ch0 highs first period", 32'(hi_seen[0]), 32'd3);
    checkOutput("ch0 done first period", 32'(pd_seen[0]), 32'd1);
    clear_seen();
    idle(20);
    checkOutput("ch0 highs two periods", 32'(hi_seen[0]), 32'd6);
    checkOutput("ch0 done two periods", 32'(pd_seen[0]), 32'd2);

    $display("[TB] glitch-free update ch1");
    applyStimulus(8'h21, 16'd1, 32'd8);
    applyStimulus(8'h22, 16'd1, 32'd4);
    applyStimulus(8'h20, 16'd0, 32'h3);
    clear_seen();
    idle(2);
    applyStimulus(8'h22, 16'd1, 32'd6);
    idle(5);
    checkOutput("ch1 highs old period", 32'(hi_seen[1]), 32'd4);
    checkOutput("ch1 done old period", 32'(pd_seen[1]), 32'd1);
    clear_seen();
    idle(8);
    checkOutput("ch1 highs new period", 32'(hi_seen[1]), 32'd6);
    checkOutput("ch1 done new period", 32'(pd_seen[1]), 32'd1);

    $display("[TB] boundaries on ch2");
    applyStimulus(8'h21, 16'd2, 32'd6);
    applyStimulus(8'h22, 16'd2, 32'd0);
    applyStimulus(8'h20, 16'd0, 32'h7);
    clear_seen();
    idle(12);
    checkOutput("ch2 hi=0 highs", 32'(hi_seen[2]), 32'd0);
    checkOutput("ch2 hi=0 done", 32'(pd_seen[2]), 32'd2);
    applyStimulus(8'h20, 16'd0, 32'h3);
    applyStimulus(8'h21, 16'd2, 32'd12);
    applyStimulus(8'h22, 16'd2, 32'd12);
    applyStimulus(8'h20, 16'd0, 32'h7);
    clear_seen();
    idle(24);
    checkOutput("ch2 hi=per highs", 32'(hi_seen[2]), 32'd24);
    checkOutput("ch2 hi=per done", 32'(pd_seen[2]), 32'd2);
    applyStimulus(8'h20, 16'd0, 32'h3);
    applyStimulus(8'h21, 16'd2, 32'd0);
    applyStimulus(8'h22, 16'd2, 32'd3);
    applyStimulus(8'h20, 16'd0, 32'h7);
    clear_seen();
    idle(5);
    checkOutput("ch2 per=0 highs", 32'(hi_seen[2]), 32'd0);
    checkOutput("ch2 per=0 done", 32'(pd_seen[2]), 32'd0);
    applyStimulus(8'h21, 16'd2, 32'd5);
    clear_seen();
    idle(1);
    checkOutput("ch2 per=5 not yet", 32'(hi_seen[2]), 32'd0);
    idle(1);
    checkOutput("ch2 per=5 started", 32'(hi_seen[2]), 32'd1);

    $display("[TB] enable/disable ch2-ch3");
    applyStimulus(8'h21, 16'd3, 32'd10);
    applyStimulus(8'h22, 16'd3, 32'd6);
    applyStimulus(8'h20, 16'd0, 32'h0C);
    idle(2);
    applyStimulus(8'h20, 16'd0, 32'h04);
    checkOutput("ch3 high at disable edge", 32'(sig_out[3]), 32'd1);
    clear_seen();
    idle(1);
    checkOutput("ch3 low after disable", 32'(sig_out[3]), 32'd0);
    idle(4);
    checkOutput("ch3 no done after disable", 32'(pd_seen[3]), 32'd0);

    $display("[TB] asynchronous reset mid-period");
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset sig_out", 32'(sig_out), 32'd0);
    checkOutput("async reset period_done", 32'(period_done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    $display("[TB] readback");
    applyStimulus(8'h20, 16'd0, 32'h5);
    applyStimulus(8'h21, 16'd3, 32'd1000);
    applyStimulus(8'h23, 16'd3, 32'd0);
    checkOutput("rb tx_en set", 32'(tx_en), 32'(RB_EN));
    checkOutput("rb per_sh word", tx_data, RB_EN ? 32'd1000 : 32'd0);
    idle(3);
    checkOutput("rb tx_en held", 32'(tx_en), 32'(RB_EN));
    applyStimulus(8'h23, 16'd3, 32'd3);
    checkOutput("rb mask word", tx_data, RB_EN ? 32'h5 : 32'd0);
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    checkOutput("rb tx_en cleared", 32'(tx_en), 32'd0);
    applyStimulus(8'h23, 16'd7, 32'd0);
    checkOutput("rb bad addr no response", 32'(tx_en), 32'd0);

    $display("[TB] randomized commands");
    for (int n = 0; n < 800; n++) begin
      int sel;
      sel        = $urandom_range(0, 9);
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_addr   = 16'($urandom_range(0, 5));
      tx_done    = ($urandom_range(0, 3) == 0);
      case (sel)
        0: begin cmd_opcode = 8'h20; cmd_data = $urandom; end
        1, 2, 3: begin cmd_opcode = 8'h21; cmd_data = $urandom_range(0, 9); end
        4, 5, 6: begin cmd_opcode = 8'h22; cmd_data = $urandom_range(0, 11); end
        7, 8: begin cmd_opcode = 8'h23; cmd_data = $urandom; end
        default: begin cmd_opcode = 8'h24; cmd_data = $urandom; end
      endcase
      cycle();
    end
    cmd_valid = 1'b0;
    tx_done   = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digital_signal_generator.md
# digital_signal_generator

Multi-channel programmable pulse/PWM generator, the stimulus-side counterpart to the signal analyzer. It drives per-channel square waves with cycle-exact period and high time from the same host command bus (opcode/addr/data/valid) and answers configuration readback over the shared tx_data/tx_en/tx_done link. Each channel uses double-buffered settings: host writes land in shadow registers and take effect only at a period boundary, so the output never glitches.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 32, width of period/high/counter registers (≤32)
- clk  in  1  system clock (100 MHz); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_opcode  in  8  command code
- cmd_addr  in  16  channel index
- cmd_data  in  32  command payload
- cmd_valid  in  1  command strobe, one cycle per command
- sig_out  out  NUM_CH  registered waveform outputs
- period_done  out  NUM_CH  one-cycle pulse at each completed period
- tx_data  out  32  readback word
- tx_en  out  1  readback valid, held until tx_done
- tx_done  in  1  host link consumed tx_data

## Operation
- Commands are decoded when cmd_valid=1. Unknown opcodes are ignored.
  - 0x20: en_mask <= cmd_data[NUM_CH-1:0]
  - 0x21: per_sh[cmd_addr] <= cmd_data[CNT_W-1:0]
  - 0x22: hi_sh[cmd_addr] <= cmd_data[CNT_W-1:0]
  - 0x23: readback (see Configuration)
- For 0x21/0x22/0x23, cmd_addr ≥ NUM_CH makes the command a no-op.
- Per-channel state: en, per_act, hi_act, cnt. States are DISABLED and RUNNING.
- DISABLED → RUNNING on the edge where en goes 0→1:
  - cnt <= 0
  - per_act <= per_sh, hi_act <= hi_sh
- RUNNING → DISABLED on the edge where en goes 1→0:
  - cnt <= 0
  - sig_out <= 0 on the following edge
  - no period_done pulse
- RUNNING with per_act ≥ 1, each edge:
  - sig_out <= (cnt < hi_act)
  - if cnt == per_act-1: cnt <= 0, per_act/hi_act <= shadows, period_done <= 1
  - otherwise: cnt <= cnt+1
- Special values:
  - per_act == 0: output low, no period_done. Shadows are reloaded every cycle, so the channel leaves this state one cycle after a nonzero period is written.
  - hi_act == 0: constant low.
  - hi_act ≥ per_act: constant high. period_done still pulses.
- Comparisons are unsigned at CNT_W width. cnt never exceeds per_act-1, so it cannot wrap.
- Shadow write and boundary reload on the same edge: the reload takes the old shadow value. The new value applies at the next boundary.
- Channels are fully independent. Writing 0x20 with an unchanged bit does not restart that channel.

## Timing
- Reset values: sig_out=0, period_done=0, tx_data=0, tx_en=0, en_mask=0, per_sh=hi_sh=0, per_act=hi_act=0, cnt=0.
- Latency from enable: the 0x20 command is sampled at edge E. The first sig_out level is valid after edge E+1.
- Output shape: sig_out is high for exactly hi_act cycles, then low for per_act−hi_act cycles.
- period_done timing: it is asserted after the edge on which the last cycle of a period was counted, coincident with sig_out presenting that period's final level.
- Readback handshake:
  - tx_en rises the edge after the 0x23 command and stays high until tx_done is sampled high.
  - A 0x23 arriving while tx_en=1 overwrites tx_data and keeps tx_en=1; cmd_valid takes priority over tx_done in the same cycle.
  - tx_done while tx_en=0 is ignored.
- Reset mid-operation: all state clears immediately and asynchronously. Outputs are low with no partial pulse after release.

## Configuration
- SIGGEN_READBACK_EN defined:
  - opcode 0x23 loads tx_data according to cmd_data[1:0]: 0 = per_sh, 1 = hi_sh, 2 = per_act, 3 = en_mask, all zero-extended.
  - tx_en is then set.
- SIGGEN_READBACK_EN undefined:
  - 0x23 is ignored.
  - tx_data and tx_en are tied to 0 and tx_done is unused.
  - All generation behaviour is identical.

## Test plan
- Basic waveform: ch0 per=10, hi=3, enable mask 0x1 → sig_out[0] repeats 3 high / 7 low, period_done[0] every 10 cycles, first high the cycle after the enable edge.
- Glitch-free update: ch1 running at per=8, hi=4; write hi=6 mid-period → current period keeps 4 high, next period shows 6 high/2 low, no runt pulse.
- Boundaries:
  - hi=0 → constant low.
  - hi=12 with per=12 → constant high, period_done still every 12 cycles.
  - per=0 → low with no period_done; writing per=5 starts output one cycle later.
- Enable/disable: ch2–ch3 enabled via 0x0C then disabled via 0x04 mid-high → sig_out[3] low on the next edge; ch2 undisturbed. Assert rst_n low mid-period → all outputs 0 immediately.
- Readback (SIGGEN_READBACK_EN):
  - write per=1000 to ch3, issue 0x23 addr 3 data 0 → tx_data=1000 and tx_en=1 until tx_done.
  - a second 0x23 with data 3 before tx_done → tx_data=mask and tx_en stays high.
  - addr 7 → no response.
- Build without SIGGEN_READBACK_EN: 0x23 commands → tx_en stays 0; waveforms match the macro-enabled build.
